ahb3lite_interconnect_slave_arbiter: RTL

AHB3LITE_INTERCONNECT_SLAVE_ARBITER -- requirements
Module: ahb3lite_interconnect_slave_arbiter

---
 rtl/ahb3lite_interconnect_slave_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// Per-slave arbiter: chooses which master owns this slave, by highest priority with round-robin
// tie-break. The grant may only move at a switch point, and every output comes from a register.
module ahb3lite_interconnect_slave_arbiter #(
  parameter int MASTERS     = 3,
  parameter int MASTER_BITS = $clog2(MASTERS + 1),
  parameter int MIDX_BITS   = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [MASTERS-1:0]             mst_HSEL,
  input  logic [MASTERS*MASTER_BITS-1:0] mst_priority,
  input  logic [MASTERS-1:0]             mst_can_switch,
  input  logic                           slv_HREADY,
  output logic [MASTERS-1:0]             master_granted,
  output logic [MIDX_BITS-1:0]           master_sel,
  output logic                           grant_valid
);

  localparam logic NO_OWNER = 1'b0;
  localparam logic OWNED    = 1'b1;

  logic                   state_q;
  logic [MIDX_BITS-1:0]   owner_q;
  logic [MIDX_BITS-1:0]   rr_ptr_q;
  logic [MASTER_BITS-1:0] prio [MASTERS];
  logic [MASTER_BITS-1:0] max_prio;
  logic                   any_req;
  logic                   found;
  logic [MIDX_BITS-1:0]   winner;
  logic [MASTERS-1:0]     winner_onehot;
  logic                   switch_point;

  always_comb begin
    for (int i = 0; i < MASTERS; i++) begin
      prio[i] = mst_priority[i*MASTER_BITS +: MASTER_BITS];
    end
  end

  // First pass finds the best requested priority; second pass walks from rr_ptr+1 with wrap
  // and takes the first requester at that priority.
  always_comb begin
    int idx;
    max_prio = '0;
    any_req  = 1'b0;
    for (int i = 0; i < MASTERS; i++) begin
      if (mst_HSEL[i] && (!any_req || (prio[i] > max_prio))) begin
        max_prio = prio[i];
        any_req  = 1'b1;
      end
    end
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= MASTERS; k++) begin
      idx = (int'(rr_ptr_q) + k) % MASTERS;
      if (!found && mst_HSEL[idx] && (prio[idx] == max_prio)) begin
        winner = MIDX_BITS'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    winner_onehot         = '0;
    winner_onehot[winner] = 1'b1;
  end

  assign switch_point = slv_HREADY && ((state_q == NO_OWNER) || mst_can_switch[owner_q]);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q        <= NO_OWNER;
      owner_q        <= '0;
      rr_ptr_q       <= MIDX_BITS'(MASTERS - 1);
      master_granted <= '0;
    end else if (switch_point && any_req) begin
      state_q        <= OWNED;
      owner_q        <= winner;
      rr_ptr_q       <= winner;
      master_granted <= winner_onehot;
    end
  end

  assign master_sel  = owner_q;
  assign grant_valid = (state_q == OWNED);

endmodule
